metaball_compositor: RTL
========================

# metaball_compositor

Parametrised pixel sequencer and field compositor that sits between a bank of `metaball` field evaluators and the double-buffered top/bottom framebuffer pair feeding `dspl_ctrl`. Per pixel it:
- broadcasts the sample coordinate and a start strobe;
- collects one single-cycle result from each of `N_BALLS` channels, which may arrive in any order and any cycle;
- sums the results with saturation and maps the sum to a 3-bit RGB colour through a mono or two-band threshold;
- writes every pixel, including dark ones, to the correct half-buffer.

One frame pass runs per `frame_go`. A buffer-swap pulse marks the end of the pass.

## Interface
Parameters:
- `N_BALLS`, default 2: number of metaball channels (1–8).
- `COLS`, default 32: pixels per row.
- `ROWS`, default 32: pixel rows. Must be even; the top buffer holds rows 0..ROWS/2-1.
- `STEP`, default 32'h0000_8000: Q16.16 pitch between adjacent pixel centres.
- `THR_LO`, default 32'h0000_8000: lower field threshold (Q16.16).
- `THR_HI`, default 32'h0001_0000: upper field threshold, used in mode 1 only. Must satisfy THR_HI ≥ THR_LO.
- `COLOR_MODE`, default 0: 0 = mono, 1 = two-band.
- `AW`, derived: $clog2(COLS*ROWS/2), the half-buffer address width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `frame_go`  in  1  request to start one frame pass. Sampled only in IDLE.
- `mb_vld`  in  N_BALLS  per-channel result-valid pulses.
- `mb_val`  in  32*N_BALLS  per-channel field values. Channel i occupies bits [32i+31:32i]; unsigned Q16.16.
- `px_stb`  out  1  start-of-pixel strobe to all metaballs.
- `p_x`, `p_y`  out  32 each  Q16.16 sample coordinate.
- `w_en_top`, `w_en_btm`  out  1 each  half-buffer write enables.
- `w_addr`  out  AW  write address within the selected half.
- `w_data`  out  3  pixel colour {R,G,B}.
- `swap_en`  out  1  buffer-swap pulse.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, SWAP. All outputs are registered.
- **IDLE**
  - `frame_go` = 1 → ISSUE, with col = row = 0.
  - `frame_go` in any other state is ignored.
- **ISSUE** (1 cycle)
  - `px_stb` = 1.
  - The sticky per-channel valid vector `got` clears.
  - Next state is WAIT.
- **WAIT**
  - For each channel, `mb_vld[i]` = 1 sets `got[i]` and captures `mb_val[i]`.
  - A repeat pulse on an already-received channel overwrites the captured value.
  - Once `got` (including pulses arriving this cycle) is all ones → WRITE.
  - There is no timeout.
- `mb_vld` pulses arriving in IDLE, ISSUE, WRITE or SWAP are discarded.
- **Summation**
  - Unsigned sum of captured values, computed at width 32+$clog2(N_BALLS+1).
  - If the sum exceeds 32'hFFFF_FFFF it saturates to that value.
- **Colour mapping**
  - Mode 0: sum ≥ THR_LO → 3'b111; otherwise 3'b000.
  - Mode 1: sum ≥ THR_HI → 3'b111; else sum ≥ THR_LO → 3'b100; else 3'b000.
- **WRITE** (1 cycle)
  - Exactly one write enable is high: `w_en_top` if row < ROWS/2, else `w_en_btm`.
  - `w_addr` = (row mod ROWS/2)*COLS + col.
  - `w_data` carries the mapped colour.
  - Then advance the pixel:
    - col < COLS-1 → col+1, next state ISSUE.
    - Otherwise col = 0. If row < ROWS-1 → row+1, next state ISSUE. Otherwise row = 0, next state SWAP.
- **SWAP** (1 cycle)
  - `swap_en` = 1.
  - Next state is IDLE.
- **Coordinates**
  - `p_x` = col*STEP and `p_y` = row*STEP, truncated to 32 bits.
  - Updated on entry to ISSUE and stable through WRITE.
- **Reset** (including mid-frame)
  - Next cycle: state IDLE, col/row 0, `got` 0.
  - `p_x`/`p_y` 0, `w_addr` 0, `w_data` 0.
  - `px_stb`, `w_en_top`, `w_en_btm`, `swap_en`, `busy` all 0.
  - No write and no swap is produced for the interrupted frame.

## Timing
- `frame_go` high in IDLE at cycle t → `px_stb` and `busy` high at t+1.
- If the last channel's valid lands at cycle w (w ≥ ISSUE cycle + 1) → write enable at w+1, next `px_stb` at w+2.
- Minimum pixel period is 3 cycles (ISSUE, WAIT, WRITE).
- `swap_en` is high in the cycle after the last pixel's write. IDLE follows, with `busy` low one cycle after that.
- A full frame is exactly COLS*ROWS writes, with no gaps or repeats. Addresses 0..COLS*ROWS/2-1 are written in order to the top half, then the same range to the bottom half.
- `px_stb`, `w_en_*` and `swap_en` are never high for more than one consecutive cycle, and are never high simultaneously.

## Test plan
- **Defaults, mono field.** Both channels return 32'h0000_4000 one cycle after each `px_stb`. Required: 1024 writes, 512 to the top half then 512 to the bottom, address 0..511 each. All `w_data` = 3'b111 (sum = THR_LO boundary). One `swap_en` pulse, then `busy` = 0.
- **Skewed arrival.** N_BALLS = 3. Channel 2 is valid at +1, channel 0 at +4 with a repeat at +6, channel 1 at +6. Required: write at +7, using channel 0's second value in the sum.
- **Two-band mode.** Sums of 32'h0000_7FFF, 32'h0000_8000 and 32'h0001_0000 map to 000, 100 and 111 respectively. Two channels at 32'hFFFF_0000 each saturate to 111 without wrapping.
- **Stray pulses.** `mb_vld` during ISSUE and during WRITE are ignored. `frame_go` held high throughout the frame starts no second pass until after the swap.
- **Reset mid-frame.** Assert `rst` in WAIT at pixel 300. Required next cycle: all outputs 0 and IDLE. A subsequent `frame_go` restarts at `p_x` = `p_y` = 0, `w_addr` 0.
- **Small geometry.** COLS = 4, ROWS = 2, STEP = 32'h0001_0000. Required: `p_x` sequence 0, 1.0, 2.0, 3.0, 0, …; `p_y` = 1.0 for the last four pixels; 4 top writes and 4 bottom writes with `w_addr` 0..3 each.

Source files
------------

// File: rtl/metaball_compositor.sv
// metaball_compositor
// Walks the pixel grid one pixel at a time. For each pixel it broadcasts the
// sample coordinate with a start strobe, gathers one field value from every
// metaball channel, sums them with saturation, thresholds the sum to a 3-bit
// colour and writes that colour into the top or bottom half-buffer. After the
// last pixel of the frame it raises a one-cycle buffer-swap pulse.
//
// Channel protocol: px_stb is a one-cycle "start this pixel" strobe. Each
// channel answers with a one-cycle mb_vld[i] pulse carrying mb_val[i], at any
// later cycle and in any order. There is no back-pressure, so no ready signal
// exists. Pulses are only accepted while waiting for results. A repeat pulse
// on a channel that already answered replaces its value.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   frame_go             start one frame pass (sampled only when idle)
//   mb_vld / mb_val      per-channel result pulses and Q16.16 values
//   px_stb               start-of-pixel strobe
//   p_x, p_y             Q16.16 sample coordinate
//   w_en_top, w_en_btm   half-buffer write enables
//   w_addr, w_data       write address within the half, colour {R,G,B}
//   swap_en              end-of-frame buffer-swap pulse
//   busy                 high while a frame pass is in progress
//   dbg_state            current FSM state, for observation only
module metaball_compositor #(
  parameter int          N_BALLS    = 2,
  parameter int          COLS       = 32,
  parameter int          ROWS       = 32,
  parameter logic [31:0] STEP       = 32'h0000_8000,
  parameter logic [31:0] THR_LO     = 32'h0000_8000,
  parameter logic [31:0] THR_HI     = 32'h0001_0000,
  parameter int          COLOR_MODE = 0,
  parameter int          AW         = $clog2(COLS*ROWS/2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_go,
  input  logic [N_BALLS-1:0]    mb_vld,
  input  logic [32*N_BALLS-1:0] mb_val,
  output logic                  px_stb,
  output logic [31:0]           p_x,
  output logic [31:0]           p_y,
  output logic                  w_en_top,
  output logic                  w_en_btm,
  output logic [AW-1:0]         w_addr,
  output logic [2:0]            w_data,
  output logic                  swap_en,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int          SW       = 32 + $clog2(N_BALLS+1);
  localparam int          CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int          RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [31:0] HALF     = 32'(ROWS/2);
  localparam logic [31:0] COLS_W   = 32'(COLS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_SWAP  = 3'd4
  } state_t;

  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [N_BALLS-1:0] got;
  logic [31:0]      cap [N_BALLS];

  logic [31:0]      eff [N_BALLS];
  logic [N_BALLS-1:0] got_n;
  logic [SW-1:0]    sum_c;
  logic [31:0]      sat_c;
  logic [2:0]       color_c;
  logic             row_top;
  logic [31:0]      row_in_half;
  logic [AW-1:0]    addr_c;
  logic [CW-1:0]    col_nx;
  logic [RW-1:0]    row_nx;
  logic             frame_end;

  // The transition into WRITE happens in the same cycle the last result
  // arrives, so the sum must see this cycle's pulses merged over the captured
  // values (eff) rather than only the registered copies.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      eff[i] = mb_vld[i] ? mb_val[32*i +: 32] : cap[i];
      sum_c  = sum_c + SW'(eff[i]);
    end
    got_n = got | mb_vld;
    sat_c = (sum_c > SW'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : sum_c[31:0];

    if (COLOR_MODE == 1)
      color_c = (sat_c >= THR_HI) ? 3'b111 : (sat_c >= THR_LO) ? 3'b100 : 3'b000;
    else
      color_c = (sat_c >= THR_LO) ? 3'b111 : 3'b000;

    row_top     = (32'(row) < HALF);
    row_in_half = row_top ? 32'(row) : 32'(row) - HALF;
    addr_c      = AW'(row_in_half * COLS_W + 32'(col));

    frame_end = (col == COL_LAST) && (row == ROW_LAST);
    col_nx    = (col == COL_LAST) ? '0 : col + CW'(1);
    row_nx    = (col != COL_LAST) ? row : (row == ROW_LAST) ? '0 : row + RW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      got      <= '0;
      for (int i = 0; i < N_BALLS; i++) cap[i] <= '0;
      p_x      <= '0;
      p_y      <= '0;
      w_addr   <= '0;
      w_data   <= '0;
      px_stb   <= 1'b0;
      w_en_top <= 1'b0;
      w_en_btm <= 1'b0;
      swap_en  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared every cycle unless re-asserted below.
      px_stb   <= 1'b0;
      w_en_top <= 1'b0;
      w_en_btm <= 1'b0;
      swap_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_go) begin
            state  <= S_ISSUE;
            col    <= '0;
            row    <= '0;
            p_x    <= '0;
            p_y    <= '0;
            px_stb <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_ISSUE: begin
          got   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          got <= got_n;
          for (int i = 0; i < N_BALLS; i++) cap[i] <= eff[i];
          if (&got_n) begin
            state    <= S_WRITE;
            w_en_top <= row_top;
            w_en_btm <= !row_top;
            w_addr   <= addr_c;
            w_data   <= color_c;
          end
        end
        S_WRITE: begin
          col <= col_nx;
          row <= row_nx;
          if (frame_end) begin
            state   <= S_SWAP;
            swap_en <= 1'b1;
          end else begin
            state  <= S_ISSUE;
            px_stb <= 1'b1;
            p_x    <= 32'(col_nx) * STEP;
            p_y    <= 32'(row_nx) * STEP;
          end
        end
        S_SWAP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
